// File: rtl/fu_share_scheduler_if.sv
// ---------------------------------------------------------------------------
// fu_share_scheduler_if
// Purpose : bundles the requester-side handshake and the function-unit
//           start/done protocol of fu_share_scheduler into one interface.
// Signals : req_valid/req_data/req_ready   requester handshake (NUM_REQ lanes)
//           rsp_valid/rsp_data/rsp_err     one-hot response pulse + result
//           busy                           scheduler not idle
//           fu_start/fu_data               launch + operand to the function unit
//           fu_done/fu_result              done level + result from the unit
// Modports: master = scheduler view, slave = environment view.
// ---------------------------------------------------------------------------
interface fu_share_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      busy;
    logic                      fu_start;
    logic [DATA_W-1:0]         fu_data;
    logic                      fu_done;
    logic [DATA_W-1:0]         fu_result;

    modport master (
        input  req_valid, req_data, fu_done, fu_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, fu_start, fu_data
    );

    modport slave (
        output req_valid, req_data, fu_done, fu_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, fu_start, fu_data
    );
endinterface

// File: rtl/fu_share_scheduler.sv
// ---------------------------------------------------------------------------
// fu_share_scheduler
// Purpose : round-robin scheduler sharing one single-input function unit
//           between NUM_REQ requesters. One request in flight at a time:
//           IDLE (grant) -> ISSUE (fu_start pulse) -> WAIT (fu_done) ->
//           RESP (one-hot rsp_valid to the owner) -> IDLE.
// Ports   : clk      rising-edge clock
//           reset_n  asynchronous active-low reset
//           bus      fu_share_scheduler_if.master (requester + unit signals)
// Config  : define FU_TIMEOUT_EN to enable the WAIT watchdog
//           (TIMEOUT_CYCLES WAIT cycles without fu_done -> error response).
//           Without it WAIT waits indefinitely and rsp_err is tied to 0.
// ---------------------------------------------------------------------------
module fu_share_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fu_share_scheduler_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fu_share_scheduler: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                         r_state;
    logic [PTR_W-1:0]               r_rr_ptr;
    logic [PTR_W-1:0]               r_owner;
    logic [NUM_REQ-1:0]             r_rsp_valid;
    logic [DATA_W-1:0]              r_rsp_data;
    logic [DATA_W-1:0]              r_fu_data;
    logic                           r_fu_start;
    logic                           r_busy;
    logic                           r_wait_first;

    logic [NUM_REQ-1:0][DATA_W-1:0] w_req_data;
    logic                           w_grant_vld;
    logic [PTR_W-1:0]               w_grant;
    logic [PTR_W-1:0]               w_next_ptr;
    logic [NUM_REQ-1:0]             w_ready;
    logic [NUM_REQ-1:0]             w_owner_oh;

`ifdef FU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_rsp_err;
`endif

    assign w_req_data = bus.req_data;

    // Rotating priority search starting at r_rr_ptr.
    always_comb begin
        int idx;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_grant_vld && bus.req_valid[PTR_W'(idx)]) begin
                w_grant_vld = 1'b1;
                w_grant     = PTR_W'(idx);
            end
        end
    end

    assign w_next_ptr = (w_grant == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    // Ready is combinational so a grant transfers in the same IDLE cycle;
    // gated by reset_n so nothing is offered while reset is held.
    always_comb begin
        w_ready = '0;
        if (reset_n && r_state == S_IDLE && w_grant_vld) w_ready[w_grant] = 1'b1;
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_fu_data    <= '0;
            r_fu_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_wait_first <= 1'b0;
`ifdef FU_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_fu_data  <= w_req_data[w_grant];
                        r_owner    <= w_grant;
                        r_rr_ptr   <= w_next_ptr;
                        r_fu_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_fu_start   <= 1'b0;
                    r_wait_first <= 1'b1;
`ifdef FU_TIMEOUT_EN
                    r_tmo_cnt    <= '0;
`endif
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_first <= 1'b0;
                    // First WAIT cycle may still see the previous result's
                    // done level, so it is not trusted until the next cycle.
                    if (!r_wait_first && bus.fu_done) begin
                        r_rsp_data  <= bus.fu_result;
                        r_rsp_valid <= w_owner_oh;
`ifdef FU_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef FU_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_owner_oh;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign bus.fu_start  = r_fu_start;
    assign bus.fu_data   = r_fu_data;
`ifdef FU_TIMEOUT_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_fu_share_scheduler.sv
module tb_fu_share_scheduler;
    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic por;
    always #5 clk = ~clk;

    fu_share_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

    fu_share_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- function unit model ----------------
    // mode 0: real function, 1: echo operand, 2: never completes.
    // Done clears one cycle after start (stale level visible in first WAIT cycle);
    // the operand is sampled only when the result is produced.
    int   unit_mode = 1;
    int   unit_lat  = 5;
    int   u_cnt;
    logic u_run;

    function automatic real f32_to_real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) d = {b[31], 63'd0};
        else                  d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        logic [30:0] em;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e  = int'(d[62:52]) - 896;
        em = {8'(e), d[51:29]};
        em = em + 31'(d[28]);
        return {d[63], em};
    endfunction

    function automatic logic [31:0] unit_real(input logic [31:0] xb);
        real x;
        x = f32_to_real(xb);
        return real_to_f32(0.5 * x + x * x * $cos((x - 128.0) / 128.0));
    endfunction

    always @(posedge clk) begin
        if (por) begin
            bus.fu_done   <= 1'b0;
            bus.fu_result <= '0;
            u_run         <= 1'b0;
            u_cnt         <= 0;
        end else if (bus.fu_start) begin
            u_cnt <= unit_lat;
            u_run <= 1'b1;
        end else if (u_run) begin
            if (unit_mode != 2 && u_cnt == 1) begin
                bus.fu_done   <= 1'b1;
                bus.fu_result <= (unit_mode == 0) ? unit_real(bus.fu_data) : bus.fu_data;
                u_run         <= 1'b0;
            end else begin
                bus.fu_done <= 1'b0;
                u_cnt       <= u_cnt - 1;
            end
        end
    end

    // ---------------- arbitration reference ----------------
    int m_ptr = 0;

    function automatic int m_pick(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int p);
        logic [NR-1:0] r;
        r = '0;
        if (p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input int r, input logic [31:0] d, output bit ok);
        bus.req_data[r*DW +: DW] = d;
        bus.req_valid[r] = 1'b1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready[r];
            @(posedge clk); #1;
        end
        bus.req_valid[r] = 1'b0;
        if (ok) m_ptr = (r + 1) % NR;
    endtask

    task automatic wait_rsp(input int max_cyc, output bit got, output logic [NR-1:0] v,
                            output logic [31:0] d, output logic e, output int cyc);
        got = 0; v = '0; d = '0; e = 1'b0; cyc = 0;
        while (!got && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid != '0) begin
                got = 1; v = bus.rsp_valid; d = bus.rsp_data; e = bus.rsp_err;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0; por = 1'b1;
        bus.req_valid = '1; bus.req_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", bus.req_ready); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.fu_start} !== 5'b0) begin errors++;
            $display("FAIL rst_ctrl: got %b want 00000", {bus.rsp_valid, bus.rsp_err, bus.busy, bus.fu_start}); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); end
        checks++; if (bus.fu_data !== 32'h0) begin errors++; $display("FAIL rst_fu_data: got %h want 0", bus.fu_data); end
        bus.req_valid = '0;
        reset_n = 1'b1; por = 1'b0;
        m_ptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        bit ok, got; logic [NR-1:0] v; logic [31:0] d; logic e; int cyc;
        unit_mode = 0; unit_lat = 3;
        send(0, 32'h4300_0000, ok);
        wait_rsp(100, got, v, d, e, cyc);
        checks++; if (v !== 2'b01) begin errors++; $display("FAIL single_owner: got %b want 01", v); end
        checks++; if (d !== 32'h4680_8000) begin errors++; $display("FAIL single_data: got %h want 46808000", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", e); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.busy} !== 3'b000) begin errors++;
            $display("FAIL single_pulse: got %b want 000", {bus.rsp_valid, bus.busy}); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        bit ok, got; logic [NR-1:0] v; logic [31:0] d; logic e; int cyc;
        unit_mode = 0; unit_lat = 4;
        send(1, 32'h0000_0000, ok);
        wait_rsp(100, got, v, d, e, cyc);
        checks++; if (v !== 2'b10) begin errors++; $display("FAIL zero_owner: got %b want 10", v); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL zero_data: got %h want 0", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic [31:0] dd [NR];
        unit_mode = 1; unit_lat = 5;
        for (int r = 0; r < NR; r++) begin dd[r] = $urandom; bus.req_data[r*DW +: DW] = dd[r]; end
        bus.req_valid = '1;
        for (int n = 0; n < 4; n++) begin
            int p; logic [31:0] acc; bit got, rdy_bad; logic [NR-1:0] rv; logic [31:0] rd;
            @(negedge clk);
            p = m_pick(bus.req_valid);
            checks++; if (bus.req_ready !== oh(p)) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", n, bus.req_ready, oh(p)); end
            acc = dd[p];
            @(posedge clk); #1;
            m_ptr = (p + 1) % NR;
            dd[p] = $urandom; bus.req_data[p*DW +: DW] = dd[p];
            got = 0; rdy_bad = 0; rv = '0; rd = '0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (bus.req_ready != '0) rdy_bad = 1;
                if (bus.rsp_valid != '0) begin got = 1; rv = bus.rsp_valid; rd = bus.rsp_data; end
            end
            checks++; if (rv !== oh(p)) begin errors++; $display("FAIL rr_owner%0d: got %b want %b", n, rv, oh(p)); end
            checks++; if (rd !== acc) begin errors++; $display("FAIL rr_data%0d: got %h want %h", n, rd, acc); end
            checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL rr_ready_busy%0d: ready seen outside IDLE", n); end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] dq [2];
        bit ok;
        unit_mode = 1; unit_lat = 6;
        dq[0] = $urandom; dq[1] = $urandom;
        send(0, dq[0], ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", ok); end
        for (int q = 0; q < 2; q++) begin
            int starts; bit got, moved, rdy_bad; logic [NR-1:0] rv; logic [31:0] rd;
            starts = 0; got = 0; moved = 0; rdy_bad = 0; rv = '0; rd = '0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                starts += int'(bus.fu_start);
                if (bus.fu_data !== dq[q]) moved = 1;
                if (bus.req_ready != '0) rdy_bad = 1;
                if (bus.rsp_valid != '0) begin got = 1; rv = bus.rsp_valid; rd = bus.rsp_data; end
                if (q == 0 && c == 2) begin bus.req_data[DW +: DW] = dq[1]; bus.req_valid[1] = 1'b1; end
            end
            checks++; if (rv !== oh(q)) begin errors++; $display("FAIL b2b_owner%0d: got %b want %b", q, rv, oh(q)); end
            checks++; if (rd !== dq[q]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", q, rd, dq[q]); end
            checks++; if (starts !== 1) begin errors++; $display("FAIL b2b_starts%0d: got %0d want 1", q, starts); end
            checks++; if (moved !== 1'b0) begin errors++; $display("FAIL b2b_fu_data_stable%0d: operand changed while busy", q); end
            checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy%0d: ready seen outside IDLE", q); end
            @(posedge clk); #1;
            if (q == 0) begin
                int p;
                @(negedge clk);
                p = m_pick(bus.req_valid);
                checks++; if (bus.req_ready !== oh(p)) begin errors++; $display("FAIL b2b_ready_idle: got %b want %b", bus.req_ready, oh(p)); end
                @(posedge clk); #1;
                bus.req_valid = '0;
                m_ptr = (p + 1) % NR;
            end
        end
    endtask

    task automatic test_random;
        unit_mode = 1;
        for (int n = 0; n < 12; n++) begin
            logic [NR-1:0] v; logic [31:0] dd [NR]; int p; logic [31:0] acc;
            bit got, rdy_bad; logic [NR-1:0] rv; logic [31:0] rd; logic re;
            unit_lat = $urandom_range(2, 8);
            v = NR'($urandom_range(1, (1 << NR) - 1));
            for (int r = 0; r < NR; r++) begin dd[r] = $urandom; bus.req_data[r*DW +: DW] = dd[r]; end
            bus.req_valid = v;
            @(negedge clk);
            p = m_pick(v);
            checks++; if (bus.req_ready !== oh(p)) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", n, bus.req_ready, oh(p)); end
            acc = dd[p];
            @(posedge clk); #1;
            m_ptr = (p + 1) % NR;
            bus.req_valid = v & ~oh(p) & NR'($urandom);
            got = 0; rdy_bad = 0; rv = '0; rd = '0; re = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (bus.req_ready != '0) rdy_bad = 1;
                if (bus.rsp_valid != '0) begin got = 1; rv = bus.rsp_valid; rd = bus.rsp_data; re = bus.rsp_err; end
                if (!got && ($urandom_range(0, 3) == 0)) bus.req_valid = NR'($urandom);
            end
            checks++; if (rv !== oh(p)) begin errors++; $display("FAIL rnd_owner%0d: got %b want %b", n, rv, oh(p)); end
            checks++; if ({re, rd} !== {1'b0, acc}) begin errors++; $display("FAIL rnd_data%0d: got %b/%h want 0/%h", n, re, rd, acc); end
            checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL rnd_ready_busy%0d: ready seen outside IDLE", n); end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid;
        bit ok, got, seen; logic [NR-1:0] v; logic [31:0] d, d1; logic e; int cyc;
        unit_mode = 1; unit_lat = 10;
        send(0, $urandom, ok);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.fu_start} !== 7'b0) begin errors++;
            $display("FAIL midrst_ctrl: got %b want 0000000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.fu_start}); end
        checks++; if ({bus.rsp_data, bus.fu_data} !== 64'h0) begin errors++;
            $display("FAIL midrst_data: got %h/%h want 0/0", bus.rsp_data, bus.fu_data); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_ptr = 0;
        seen = 0;
        repeat (20) begin @(negedge clk); if (bus.rsp_valid != '0 || bus.busy) seen = 1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_quiet: activity after reset"); end
        unit_lat = 4;
        d1 = $urandom;
        @(posedge clk); #1;
        send(1, d1, ok);
        wait_rsp(100, got, v, d, e, cyc);
        checks++; if ({v, d} !== {2'b10, d1}) begin errors++; $display("FAIL midrst_next: got %b/%h want 10/%h", v, d, d1); end
        @(posedge clk); #1;
    endtask

`ifdef FU_TIMEOUT_EN
    task automatic test_timeout;
        bit ok, got; logic [NR-1:0] v; logic [31:0] d, d2; logic e; int cyc;
        unit_mode = 2;
        send(1, $urandom, ok);
        wait_rsp(200, got, v, d, e, cyc);
        checks++; if (cyc !== TMO + 2) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", cyc, TMO + 2); end
        checks++; if ({v, e, d} !== {2'b10, 1'b1, 32'h0}) begin errors++;
            $display("FAIL tmo_rsp: got %b/%b/%h want 10/1/0", v, e, d); end
        @(posedge clk); #1;
        unit_mode = 1; unit_lat = 3; d2 = $urandom;
        send(0, d2, ok);
        wait_rsp(100, got, v, d, e, cyc);
        checks++; if ({v, e, d} !== {2'b01, 1'b0, d2}) begin errors++;
            $display("FAIL tmo_recover: got %b/%b/%h want 01/0/%h", v, e, d, d2); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_zero;
        test_round_robin;
        test_back_to_back;
        test_random;
        test_reset_mid;
`ifdef FU_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
